// File: rtl/vsd_dac_stream_ctrl.sv
// ============================================================================
// vsd_dac_stream_ctrl - FIFO-buffered, rate-paced round-robin feed to avsddac
// channels. Optional macro: VSD_DAC_MIDSCALE_EN.    Rev 1.0
// ============================================================================
`default_nettype none

module vsd_dac_stream_ctrl #(
  parameter int DATA_W = 10,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic                       clr_underrun,
  output logic [NUM_CH*DATA_W-1:0]   dac_out,
  output logic [NUM_CH-1:0]          dac_strobe,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_ADDR_W:0]     c_FULL    = (c_ADDR_W+1)'(DEPTH);
  localparam logic [c_CH_W-1:0]     c_LAST_CH = c_CH_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0]     c_MID     = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef VSD_DAC_MIDSCALE_EN
  localparam logic [NUM_CH*DATA_W-1:0] c_DAC_RST = {NUM_CH{c_MID}};
`else
  localparam logic [NUM_CH*DATA_W-1:0] c_DAC_RST = '0;
`endif

  logic [DATA_W-1:0]         mem_q [DEPTH];
  logic [c_ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [c_ADDR_W:0]         level_q, level_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d;
  logic [c_CH_W-1:0]         ch_ptr_q, ch_ptr_d;
  logic [NUM_CH*DATA_W-1:0]  dac_q, dac_d;
  logic [NUM_CH-1:0]         strobe_q, strobe_d;
  logic                      underrun_q, underrun_d;

  logic w_tick, w_empty, w_push, w_pop;

  assign in_ready   = (level_q != c_FULL);
  assign w_empty    = (level_q == '0);
  assign w_tick     = enable && (cnt_q == rate_div);
  assign w_pop      = w_tick && !w_empty;
  assign w_push     = in_valid && in_ready;

  assign dac_out    = dac_q;
  assign dac_strobe = strobe_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    ch_ptr_d   = ch_ptr_q;
    dac_d      = dac_q;
    strobe_d   = '0;
    underrun_d = underrun_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (!enable) begin
      cnt_d    = '0;
      ch_ptr_d = '0;
    end else if (w_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (w_pop) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_ptr_q == c_CH_W'(k)) begin
          dac_d[k*DATA_W +: DATA_W] = mem_q[rd_ptr_q];
          strobe_d[k]               = 1'b1;
        end
      end
      ch_ptr_d = (ch_ptr_q == c_LAST_CH) ? '0 : ch_ptr_q + 1'b1;
    end

    // An empty tick sets the flag even if a clear arrives in the same cycle.
    if (w_tick && w_empty) begin
      underrun_d = 1'b1;
`ifdef VSD_DAC_MIDSCALE_EN
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_ptr_q == c_CH_W'(k)) begin
          dac_d[k*DATA_W +: DATA_W] = c_MID;
          strobe_d[k]               = 1'b1;
        end
      end
`endif
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      ch_ptr_q   <= '0;
      dac_q      <= c_DAC_RST;
      strobe_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      ch_ptr_q   <= ch_ptr_d;
      dac_q      <= dac_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

`default_nettype wire
